// File: rtl/dm_stack_mem.sv
// Single-port data memory with a hardware stack at the top of the address space.
// Push/pop manage sp and count; store/load access memory directly.
module dm_stack_mem #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 9,
  parameter int STACK_BASE = 384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store,
  input  logic              load,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] sp,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int TOP   = (1 << ADDR_W) - 1;
  localparam int DEPTH = TOP - STACK_BASE + 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [0:TOP];

  logic [CW-1:0]     count;
  logic [CW-1:0]     count_n;
  logic [ADDR_W-1:0] sp_n;
  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic              we;
  logic              re;
  logic              ovf_set;
  logic              unf_set;
  logic              g_push;
  logic              g_pop;
  logic              g_st;
  logic              g_ld;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign sp_inc = sp + ADDR_W'(1);

  // One-hot grants encode push > pop > store > load.
  assign g_push = push;
  assign g_pop  = pop & ~push;
  assign g_st   = store & ~push & ~pop;
  assign g_ld   = load & ~push & ~pop & ~store;

  always_comb begin
    we      = 1'b0;
    re      = 1'b0;
    waddr   = address;
    raddr   = address;
    sp_n    = sp;
    count_n = count;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (1'b1)
      g_push: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          we      = 1'b1;
          waddr   = sp;
          sp_n    = sp - ADDR_W'(1);
          count_n = count + CW'(1);
        end
      end
      g_pop: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          re      = 1'b1;
          raddr   = sp_inc;
          sp_n    = sp_inc;
          count_n = count - CW'(1);
        end
      end
      g_st: we = 1'b1;
      g_ld: re = 1'b1;
      default: ;
    endcase
  end

  // Contents survive reset; only the write is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= ADDR_W'(TOP);
      count     <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_n;
      count     <= count_n;
      rvalid    <= re;
      if (re) rdata <= mem[raddr];
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_dm_stack_mem.sv
// Bench for dm_stack_mem: stack/memory model checked every cycle,
// plus literal expectations along a directed sequence.
module tb_dm_stack_mem;

  localparam int TOP   = 511;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        store = 1'b0;
  logic        load = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [8:0]  address = '0;
  logic [15:0] wdata = '0;
  logic        err_clr = 1'b0;
  logic [15:0] rdata;
  logic        rvalid;
  logic [8:0]  sp;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  dm_stack_mem dut (
    .clk(clk), .rst(rst), .store(store), .load(load), .push(push),
    .pop(pop), .address(address), .wdata(wdata), .err_clr(err_clr),
    .rdata(rdata), .rvalid(rvalid), .sp(sp), .full(full),
    .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Model: memory as a sparse map, stack as an occupancy count.
  logic [15:0] mem_m [int];
  int          cnt = 0;
  logic [15:0] m_rdata = '0;
  bit          m_known = 1'b1;
  bit          m_rvalid = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt = 0; m_rdata = '0; m_known = 1'b1;
      m_rvalid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_rvalid = 1'b0;
      if (err_clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (push) begin
        if (cnt == DEPTH) m_ovf = 1'b1;
        else begin mem_m[TOP - cnt] = wdata; cnt++; end
      end else if (pop) begin
        if (cnt == 0) m_unf = 1'b1;
        else begin
          cnt--;
          m_known = mem_m.exists(TOP - cnt);
          if (m_known) m_rdata = mem_m[TOP - cnt];
          m_rvalid = 1'b1;
        end
      end else if (store) begin
        mem_m[int'(address)] = wdata;
      end else if (load) begin
        m_known = mem_m.exists(int'(address));
        if (m_known) m_rdata = mem_m[int'(address)];
        m_rvalid = 1'b1;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_sp", 32'(sp), 32'(TOP - cnt));
      chk("m_full", 32'(full), 32'(cnt == DEPTH));
      chk("m_empty", 32'(empty), 32'(cnt == 0));
      chk("m_rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_unf", 32'(underflow), 32'(m_unf));
      if (m_known) chk("m_rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  // Drive one cycle of strobes, return #1 after the edge with inputs idle.
  task automatic cyc(input logic pu, input logic po, input logic st,
                     input logic ld, input logic [8:0] a,
                     input logic [15:0] d, input logic ec);
    push = pu; pop = po; store = st; load = ld;
    address = a; wdata = d; err_clr = ec;
    @(posedge clk);
    #1;
    push = 0; pop = 0; store = 0; load = 0; err_clr = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_sp", 32'(sp), 32'd511);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);
    cyc(0, 0, 0, 0, 9'h0, 16'h0, 0);

    cyc(0, 0, 1, 0, 9'h005, 16'hBEEF, 0);
    cyc(0, 0, 0, 1, 9'h005, 16'h0, 0);
    chk("ld_rvalid", 32'(rvalid), 32'd1);
    chk("ld_rdata", 32'(rdata), 32'hBEEF);
    cyc(0, 0, 0, 0, 9'h0, 16'h0, 0);
    chk("ld_rvalid_drop", 32'(rvalid), 32'd0);
    chk("ld_hold", 32'(rdata), 32'hBEEF);

    cyc(1, 0, 0, 0, 9'h0, 16'h0001, 0);
    cyc(1, 0, 0, 0, 9'h0, 16'h0002, 0);
    cyc(1, 0, 0, 0, 9'h0, 16'h0003, 0);
    chk("push3_sp", 32'(sp), 32'd508);
    for (int i = 3; i >= 1; i--) begin
      cyc(0, 1, 0, 0, 9'h0, 16'h0, 0);
      chk("pop_rdata", 32'(rdata), 32'(i));
      chk("pop_rvalid", 32'(rvalid), 32'd1);
    end
    chk("pop_sp", 32'(sp), 32'd511);
    chk("pop_empty", 32'(empty), 32'd1);
    cyc(0, 1, 0, 0, 9'h0, 16'h0, 0);
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_rdata", 32'(rdata), 32'd1);
    chk("unf_rvalid", 32'(rvalid), 32'd0);
    cyc(0, 0, 0, 0, 9'h0, 16'h0, 1);
    chk("unf_clr", 32'(underflow), 32'd0);

    cyc(0, 0, 1, 0, 9'd383, 16'h5A5A, 0);
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 0, 0, 0, 9'h0, 16'(16'h0100 + i), 0);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_sp", 32'(sp), 32'd383);
    cyc(1, 0, 0, 0, 9'h0, 16'hDEAD, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_sp", 32'(sp), 32'd383);
    cyc(0, 0, 0, 0, 9'h0, 16'h0, 1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    cyc(1, 0, 0, 0, 9'h0, 16'hDEAD, 1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    cyc(0, 0, 0, 0, 9'h0, 16'h0, 1);
    cyc(0, 0, 0, 1, 9'd383, 16'h0, 0);
    chk("below_stack", 32'(rdata), 32'h5A5A);
    for (int i = 0; i < DEPTH; i++)
      cyc(0, 1, 0, 0, 9'h0, 16'h0, 0);
    chk("drain_last", 32'(rdata), 32'h0100);
    chk("drain_empty", 32'(empty), 32'd1);

    push = 1; store = 1; load = 1;
    address = 9'h005; wdata = 16'h1234;
    @(posedge clk);
    #1 push = 0; store = 0; load = 0;
    chk("prio_sp", 32'(sp), 32'd510);
    chk("prio_rvalid", 32'(rvalid), 32'd0);
    cyc(0, 0, 0, 1, 9'h005, 16'h0, 0);
    chk("prio_mem", 32'(rdata), 32'hBEEF);
    cyc(0, 0, 0, 1, 9'd511, 16'h0, 0);
    chk("prio_push", 32'(rdata), 32'h1234);

    cyc(1, 0, 0, 0, 9'h0, 16'hAAAA, 0);
    pop = 1;
    #2 rst = 1'b1;
    @(posedge clk);
    #1 pop = 0;
    chk("rst_mid_sp", 32'(sp), 32'd511);
    chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mid_empty", 32'(empty), 32'd1);
    chk("rst_mid_rvalid2", 32'(rvalid), 32'd0);
    cyc(0, 0, 0, 0, 9'h0, 16'h0, 0);
    chk("rst_mid_rvalid3", 32'(rvalid), 32'd0);
    cyc(0, 0, 0, 1, 9'd510, 16'h0, 0);
    chk("retain_510", 32'(rdata), 32'hAAAA);
    cyc(0, 0, 0, 1, 9'd511, 16'h0, 0);
    chk("retain_511", 32'(rdata), 32'h1234);
    cyc(0, 0, 0, 0, 9'h0, 16'h0, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
